// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction-fetch stage: PC, redirects, IF/ID register, halt freeze
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_branch_taken,
  input  logic [15:0] i_branch_imm,
  input  logic        i_jump,
  input  logic [25:0] i_jump_idx,
  input  logic        i_jump_reg,
  input  logic [31:0] i_reg_target,
  output logic [31:0] o_addr,
  input  logic [31:0] i_instr_in,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc_plus4,
  output logic        o_id_valid,
  output logic        o_halted,
  output logic [31:0] o_fetch_count
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_id_instr;
  logic [31:0] r_id_pc_plus4;
  logic        r_id_valid;
  logic        r_halted;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_jr_target;
  logic [31:0] w_j_target;
  logic [31:0] w_br_offset;
  logic [31:0] w_br_target;
  logic        w_redirect;
  logic        w_is_halt;
  logic [31:0] w_redirect_pc;

  assign w_pc_plus4  = r_pc + 32'd4;
  // Masking keeps the target word-aligned even if the register holds a byte address.
  assign w_jr_target = i_reg_target & 32'hFFFF_FFFC;
  assign w_j_target  = {r_id_pc_plus4[31:28], i_jump_idx, 2'b00};
  assign w_br_offset = {{14{i_branch_imm[15]}}, i_branch_imm, 2'b00};
  assign w_br_target = r_id_pc_plus4 + w_br_offset;
  assign w_redirect  = i_jump_reg | i_jump | i_branch_taken;
  assign w_is_halt   = (i_instr_in[31:26] == HALT_OPCODE);

  always_comb begin
    w_redirect_pc = w_br_target;
    if (i_jump_reg) begin
      w_redirect_pc = w_jr_target;
    end else if (i_jump) begin
      w_redirect_pc = w_j_target;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_id_instr    <= 32'h0000_0000;
      r_id_pc_plus4 <= 32'h0000_0000;
      r_id_valid    <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= 32'h0000_0000;
    end else if (r_state == ST_RUN) begin
      if (w_redirect) begin
        r_pc       <= w_redirect_pc;
        r_id_instr <= 32'h0000_0000;
        r_id_valid <= 1'b0;
      end else if (i_stall) begin
        if (i_flush) begin
          r_id_instr <= 32'h0000_0000;
          r_id_valid <= 1'b0;
        end
      end else if (w_is_halt) begin
        // The halt word itself never enters decode; the PC stays on it.
        r_id_instr <= 32'h0000_0000;
        r_id_valid <= 1'b0;
        r_state    <= ST_HALT;
        r_halted   <= 1'b1;
      end else begin
        r_pc <= w_pc_plus4;
        if (i_flush) begin
          r_id_instr <= 32'h0000_0000;
          r_id_valid <= 1'b0;
        end else begin
          r_id_instr    <= i_instr_in;
          r_id_pc_plus4 <= w_pc_plus4;
          r_id_valid    <= 1'b1;
          r_fetch_count <= r_fetch_count + 32'd1;
        end
      end
    end
  end

  assign o_addr        = r_pc;
  assign o_id_instr    = r_id_instr;
  assign o_id_pc_plus4 = r_id_pc_plus4;
  assign o_id_valid    = r_id_valid;
  assign o_halted      = r_halted;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed table-driven bench for pc_fetch_unit
module tb_pc_fetch_unit;

  localparam logic [31:0] WA = 32'h2001_0001;
  localparam logic [31:0] WB = 32'h2002_0002;
  localparam logic [31:0] WC = 32'h2003_0003;
  localparam logic [31:0] WD = 32'h2004_0004;
  localparam logic [31:0] WH = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst, stall, flush, br, jmp, jr;
  logic [15:0] imm;
  logic [25:0] idx;
  logic [31:0] rt, vec_instr, instr_in;
  logic        use_mem;
  logic [31:0] addr, id_instr, id_pc4, fcount;
  logic        id_valid, halted;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    instr_in = vec_instr;
    if (use_mem) begin
      case (addr)
        32'h0:   instr_in = WA;
        32'h4:   instr_in = WB;
        32'h8:   instr_in = WC;
        32'hC:   instr_in = WD;
        default: instr_in = 32'h2000_0000;
      endcase
    end
  end

  pc_fetch_unit dut (
    .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_flush(flush),
    .i_branch_taken(br), .i_branch_imm(imm), .i_jump(jmp), .i_jump_idx(idx),
    .i_jump_reg(jr), .i_reg_target(rt), .o_addr(addr), .i_instr_in(instr_in),
    .o_id_instr(id_instr), .o_id_pc_plus4(id_pc4), .o_id_valid(id_valid),
    .o_halted(halted), .o_fetch_count(fcount)
  );

  typedef struct {
    logic        rst, stall, flush, br;
    logic [15:0] imm;
    logic        jmp;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] rt, instr;
    logic [31:0] e_addr, e_instr, e_pc4;
    logic        e_valid, e_halted;
    logic [31:0] e_fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic f, logic b, logic [15:0] im,
                              logic j, logic [25:0] ix, logic jrr, logic [31:0] rtt,
                              logic [31:0] ins, logic [31:0] ea, logic [31:0] ei,
                              logic [31:0] ep, logic ev, logic eh, logic [31:0] ef);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.br = b; v.imm = im; v.jmp = j;
    v.idx = ix; v.jr = jrr; v.rt = rtt; v.instr = ins; v.e_addr = ea;
    v.e_instr = ei; v.e_pc4 = ep; v.e_valid = ev; v.e_halted = eh; v.e_fc = ef;
    return v;
  endfunction

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d actual=%h expected=%h", name, n, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; br = 1'b0; jmp = 1'b0; jr = 1'b0;
    imm = '0; idx = '0; rt = '0; vec_instr = '0; use_mem = 1'b1;

    // Memory-driven sequential fetch from reset: A,B,C,D
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_addr", 0, addr, 32'h0);
    chk("reset_valid", 0, {31'b0, id_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr_pre", i, addr, 32'(4 * i));
      @(posedge clk); #1;
      chk("seq_instr", i, id_instr, (i == 0) ? WA : (i == 1) ? WB : (i == 2) ? WC : WD);
      chk("seq_pc4", i, id_pc4, 32'(4 * (i + 1)));
      chk("seq_fc", i, fcount, 32'(i + 1));
    end
    use_mem = 1'b0;

    //        rst  stl  fl   br   imm      jmp  idx     jr   rt            instr         addr          instr pc4           v    h    fc
    vecs.push_back(mk(1, 0, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WA,           32'h0,        32'h0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WA,           32'h4,        WA,    32'h4,        1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WB,           32'h8,        WB,    32'h8,        1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WC,           32'h8,        WB,    32'h8,        1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WC,           32'h8,        WB,    32'h8,        1, 0, 2));
    vecs.push_back(mk(0, 1, 1, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WC,           32'h8,        32'h0, 32'h8,        0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 1, 16'hFFFE, 0, 26'h0,  0, 32'h0,        WC,           32'h0,        32'h0, 32'h8,        0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WA,           32'h4,        WA,    32'h4,        1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WB,           32'h8,        WB,    32'h8,        1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0003, 0, 26'h0,  0, 32'h0,        WC,           32'h14,       32'h0, 32'h8,        0, 0, 4));
    vecs.push_back(mk(0, 1, 0, 1, 16'h0001, 0, 26'h0,  0, 32'h0,        WC,           32'hC,        32'h0, 32'h8,        0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WD,           32'h10,       WD,    32'h10,       1, 0, 5));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0,    0, 26'h0,  0, 32'h0,        32'h2005_0005, 32'h14,      32'h0, 32'h10,       0, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0,  1, 32'h1000_0007, WC,          32'h1000_0004, 32'h0, 32'h10,       0, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WA,           32'h1000_0008, WA,    32'h1000_0008, 1, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0,    1, 26'h10, 0, 32'h0,        WB,           32'h1000_0040, 32'h0, 32'h1000_0008, 0, 0, 6));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0001, 1, 26'h10, 1, 32'h23,       WB,           32'h20,       32'h0, 32'h1000_0008, 0, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0,  1, 32'hFFFF_FFFF, WB,          32'hFFFF_FFFC, 32'h0, 32'h1000_0008, 0, 0, 6));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WB,           32'h0,        WB,    32'h0,        1, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WA,           32'h4,        WA,    32'h4,        1, 0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WB,           32'h8,        WB,    32'h8,        1, 0, 9));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WC,           32'hC,        WC,    32'hC,        1, 0, 10));
    vecs.push_back(mk(0, 1, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WH,           32'hC,        WC,    32'hC,        1, 0, 10));
    vecs.push_back(mk(0, 0, 1, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WH,           32'hC,        32'h0, 32'hC,        0, 1, 10));
    vecs.push_back(mk(0, 1, 1, 0, 16'h0,    1, 26'h10, 0, 32'h0,        WA,           32'hC,        32'h0, 32'hC,        0, 1, 10));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0001, 0, 26'h0,  1, 32'h40,       WD,           32'hC,        32'h0, 32'hC,        0, 1, 10));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0,    1, 26'h10, 0, 32'h0,        WA,           32'h0,        32'h0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        WA,           32'h4,        WA,    32'h4,        1, 0, 1));

    foreach (vecs[k]) begin
      rst = vecs[k].rst; stall = vecs[k].stall; flush = vecs[k].flush;
      br = vecs[k].br; imm = vecs[k].imm; jmp = vecs[k].jmp; idx = vecs[k].idx;
      jr = vecs[k].jr; rt = vecs[k].rt; vec_instr = vecs[k].instr;
      @(posedge clk); #1;
      chk("addr", k, addr, vecs[k].e_addr);
      chk("addr_align", k, {30'b0, addr[1:0]}, 32'h0);
      chk("id_instr", k, id_instr, vecs[k].e_instr);
      chk("id_pc4", k, id_pc4, vecs[k].e_pc4);
      chk("id_valid", k, {31'b0, id_valid}, {31'b0, vecs[k].e_valid});
      chk("halted", k, {31'b0, halted}, {31'b0, vecs[k].e_halted});
      chk("fetch_count", k, fcount, vecs[k].e_fc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage that sits directly upstream of the instruction memory. Owns the program counter, drives the memory address, takes back the assembled instruction word, and registers it with its PC+4 into the IF/ID pipeline register for decode. Handles stall, flush, branch/jump/jump-register redirection, and a halt opcode that freezes fetch until reset.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be a multiple of 4
- HALT_OPCODE, 6'b111111, opcode field [31:26] that halts fetch

- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Stall  in  1  hold PC and IF/ID contents (hazard from decode)
- Flush  in  1  load a bubble into IF/ID this edge
- BranchTaken  in  1  resolved taken branch for the instruction currently in IF/ID
- BranchImm  in  16  branch offset field of that instruction, in words
- Jump  in  1  J-type redirect for the instruction in IF/ID
- JumpIdx  in  26  J-type target field
- JumpReg  in  1  register-indirect redirect
- RegTarget  in  32  jump-register target address
- Addr  out  32  instruction memory address, equals PC
- InstrIn  in  32  instruction word at Addr, assembled as {opcode[31:26], rest[25:0]} from instruction memory; combinational in the same cycle
- IdInstr  out  32  IF/ID instruction register
- IdPcPlus4  out  32  IF/ID PC+4 register
- IdValid  out  1  IF/ID holds a real instruction
- Halted  out  1  fetch frozen by halt opcode
- FetchCount  out  32  count of instructions loaded into IF/ID with IdValid=1

## Operation
- FSM states: RUN, HALT. Reset -> RUN. RUN -> HALT when an edge would load an InstrIn with [31:26]==HALT_OPCODE into IF/ID. HALT -> RUN only via Reset.
- Next-state priority in RUN, evaluated each edge: Reset > JumpReg > Jump > BranchTaken > Stall > halt detect > sequential.
  - JumpReg: PC <= {RegTarget[31:2], 2'b00}.
  - Jump: PC <= {IdPcPlus4[31:28], JumpIdx, 2'b00}.
  - BranchTaken: PC <= IdPcPlus4 + ({{14{BranchImm[15]}}, BranchImm, 2'b00}), modulo 2^32.
  - On any redirect: IF/ID <= bubble (wrong-path fetch discarded); Stall ignored that edge.
  - Stall (no redirect): PC, IdInstr, IdPcPlus4, IdValid, FetchCount all hold. Flush with Stall: bubble loaded, PC holds.
  - Halt detect: PC holds, IF/ID <= bubble, state -> HALT, Halted <= 1.
  - Sequential: PC <= PC + 4 (wraps at 2^32); IdInstr <= InstrIn; IdPcPlus4 <= PC + 4; IdValid <= 1; FetchCount += 1 (wraps). Flush alone: PC advances, bubble loaded instead.
- Bubble = IdInstr 32'h0000_0000 (sll $0,$0,0), IdPcPlus4 unchanged, IdValid 0, FetchCount unchanged.
- HALT: PC, FetchCount hold; IF/ID holds bubble; all redirect, Stall, Flush inputs ignored.
- Redirect inputs with IdValid=0 are still honoured (decode gates them).

## Timing
- Reset values: PC/Addr = RESET_PC, IdInstr = 0, IdPcPlus4 = 0, IdValid = 0, Halted = 0, FetchCount = 0, state RUN. Reset mid-operation (including in HALT) restores all of these at the next edge.
- Addr is the PC register, no combinational path from inputs to Addr.
- Latency: word at Addr appears on IdInstr one edge later; redirect asserted in cycle n -> Addr = target in cycle n+1, target's word in IF/ID in n+2; one bubble cycle per redirect.
- Addr[1:0] always 00.
- Halted asserts the edge after the halt word is presented.

## Test plan
- Reset, RESET_PC=0, memory 0x00..0x0C = A,B,C,D, no stalls -> Addr 0,4,8,C; IdInstr A,B,C,D with IdPcPlus4 4,8,C,10; FetchCount 4 after 4 loads.
- Stall held 2 cycles while IF/ID = B -> IdInstr stays B, Addr stays 8, FetchCount unchanged; Stall+Flush -> IdValid 0, Addr still 8.
- BranchTaken with IdPcPlus4=0x8, BranchImm=16'hFFFE -> next Addr 0x0, IdValid 0 for one cycle; BranchImm=16'h0003 -> Addr 0x14.
- Jump with IdPcPlus4=0x1000_0008, JumpIdx=26'h10 -> Addr 0x1000_0040; same cycle JumpReg RegTarget=0x23 -> Addr 0x20 (JumpReg wins, low bits cleared).
- Word 0xFC00_0000 at 0x0C -> Halted 1, Addr frozen at 0xC, IdValid 0; later Jump ignored; Reset -> Addr 0, Halted 0, FetchCount 0.
- PC = 0xFFFF_FFFC sequential -> Addr wraps to 0x0, IdPcPlus4 = 0x0.
